noc_switch_n: RTL and testbench
===============================

// Module: noc_switch_n
// PURPOSE
//  Parametrised NOC fan-out switch: one upstream NOC port to NDEV downstream device ports.
//  Request packets are routed by destination ID; all other device ports receive NOPs.
//  Device responses are buffered per port, one packet-aware FIFO per device.
//  Buffered responses are merged upstream by a packet-granular round-robin arbiter.
//  Successor to the fixed 2-device switch: generalised NDEV/DEPTH/BASE_ID, adds drop/overflow flags.
// PARAMETERS
//  NDEV     4      number of downstream device ports (2..8)
//  BASE_ID  8'h40  destination ID of device 0; device i answers to BASE_ID+i
//  DEPTH    16     response FIFO entries per device (power of 2, >= max response length+1)
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        asynchronous, active-high
//  to_ctl         in   1        upstream request ctl (1=cmd/NOP, 0=data byte)
//  to_data        in   8        upstream request byte
//  from_ctl       out  1        upstream response ctl
//  from_data      out  8        upstream response byte
//  dev_to_ctl     out  NDEV     per-device request ctl
//  dev_to_data    out  8*NDEV   per-device request byte, device i at [8i+7:8i]
//  dev_from_ctl   in   NDEV     per-device response ctl
//  dev_from_data  in   8*NDEV   per-device response byte
//  bad_dest       out  1        sticky: a packet with out-of-range dest ID was dropped
//  ovf            out  NDEV     sticky per device: response byte dropped on full FIFO
// BEHAVIOUR
//  NOP = {ctl=1,data=8'h00}. Packet = non-NOP cmd byte, then dest ID byte (ctl=0), then ctl=0 bytes.
//  Reset (async): delay line=NOP, dest_q=BASE_ID, FIFOs empty, arbiter idle, ptr=0.
//   All outputs are NOP; bad_dest=0; ovf=0.
//  Request path:
//   - 2-stage delay line on {to_ctl,to_data}.
//   - dest_q loads on first ctl=0 byte after a non-NOP cmd (states IDLE->GOT_CMD->ROUTE).
//   - Cmd byte on to_* at cycle t appears on the dev_to_* of the selected port at t+2.
//   - The selected port's dest_q takes effect for that same cmd byte.
//   - Unselected ports drive NOP.
//   - Route holds through ctl=1 NOPs until the next packet's dest ID is captured.
//   - dest_q-BASE_ID >= NDEV: whole packet dropped (all ports NOP); bad_dest set.
//   - Back-to-back packets with zero NOPs between them are routed correctly.
//  Response capture, per device, states WAIT/STORE:
//   - WAIT: non-NOP cmd -> write, go STORE; NOPs ignored.
//   - STORE: write every byte; a NOP is written as terminator, pkt_cnt++, go WAIT.
//   - Write when full: byte dropped, ovf[i] set. A dropped terminator still ends the packet (pkt_cnt++).
//  Arbiter, states IDLE/SEND:
//   - IDLE: grant the first device with pkt_cnt>0, searching from ptr upward with wrap NDEV-1->0.
//   - SEND: pop one entry per cycle onto the registered from_* outputs.
//   - On popping the terminator: pkt_cnt--, ptr=grant+1 mod NDEV, go IDLE.
//   - Grant is locked for the whole packet; never interleave packets.
//   - from_* = NOP whenever idle.
//   - Minimum latency: terminator written at t -> cmd byte on from_* at t+2.
//   - Simultaneous write and pop on one FIFO is allowed; count unchanged.
//   - Simultaneous pkt_cnt++ and pkt_cnt-- nets to zero.
//   - Occupancy width is $clog2(DEPTH)+1; pointers wrap naturally.
//  Reset mid-packet: partial packets are discarded; no recovery beyond the reset values above.
// STRUCTURE
//  noc_pkg:
//   - NOP_CTL/NOP_DATA constants.
//   - typedef struct packed {logic ctl; logic [7:0] data;} noc_byte_t.
//   - enums req_st_t{IDLE,GOT_CMD,ROUTE}, cap_st_t{WAIT,STORE}, arb_st_t{A_IDLE,A_SEND}.
//  Sub-module noc_rsp_buf:
//   - FIFO, capture FSM, pkt_cnt and ovf.
//   - Generated NDEV times.
//  Top level: request delay/route logic and RR arbiter.
// TESTING
//  T1 reset mid-traffic, reset held 3 cycles:
//   - all dev_to_* and from_* = NOP; flags=0.
//   - first post-reset packet routed normally.
//  T2 cmd 8'h81, id 8'h42, data 8'h10, 8'h20:
//   - dev 2 sees 81,42,10,20 at t+2..t+5; devs 0,1,3 see NOP.
//  T3 id 8'h47 with NDEV=4:
//   - all ports NOP for the packet; bad_dest=1.
//   - next packet (id 8'h40) reaches dev 0.
//  T4 devs 0,1,3 each return cmd+3 data+NOP in the same cycle:
//   - from_* carries packets in order 0,1,3 with no interleave.
//   - ptr ends at 0; minimum gap between packets is 1 cycle.
//  T5 dev 1 returns DEPTH+4 bytes while the arbiter is blocked on dev 0:
//   - ovf[1]=1; FIFO never exceeds DEPTH.
//   - pkt_cnt[1]=1 after the terminator.
//  T6 dev 2 streams while the arbiter drains it (concurrent read/write):
//   - from_* byte-exact copy of the dev 2 response; no ovf.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NOC byte type, NOP encoding and FSM state types for the fan-out switch.
package noc_pkg;

  localparam logic       NOP_CTL  = 1'b1;
  localparam logic [7:0] NOP_DATA = 8'h00;

  typedef struct packed {
    logic       ctl;
    logic [7:0] data;
  } noc_byte_t;

  localparam noc_byte_t NOC_NOP = '{ctl: NOP_CTL, data: NOP_DATA};

  typedef enum logic [1:0] {IDLE, GOT_CMD, ROUTE} req_st_t;
  typedef enum logic       {WAIT, STORE}          cap_st_t;
  typedef enum logic       {A_IDLE, A_SEND}       arb_st_t;

  function automatic logic is_nop(input noc_byte_t b);
    return (b.ctl == NOP_CTL) && (b.data == NOP_DATA);
  endfunction

  // A command byte is any ctl=1 byte that is not a NOP.
  function automatic logic is_cmd(input noc_byte_t b);
    return (b.ctl == NOP_CTL) && (b.data != NOP_DATA);
  endfunction

endpackage

// File: rtl/noc_rsp_buf.sv
// Per-device response buffer: packet-aware capture into a FIFO, completed
// packet count for the arbiter, and a sticky overflow flag.
module noc_rsp_buf
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  noc_byte_t rsp,
  input  logic      pop,
  input  logic      pkt_done,
  output noc_byte_t head,
  output logic      empty,
  output logic      has_pkt,
  output logic      ovf
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  noc_byte_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   pkt_cnt;
  cap_st_t       st;
  logic          full;
  logic          wr_req;
  logic          wr_en;
  logic          rd_en;
  logic          term;

  // Decode write/read requests and FIFO status.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_FULL);
    has_pkt = (pkt_cnt != '0);
    wr_req  = (st == STORE) || is_cmd(rsp);
    term    = (st == STORE) && is_nop(rsp);
    wr_en   = wr_req && !full;
    rd_en   = pop && !empty;
    head    = mem[rd_ptr];
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rsp;
  end

  // Capture FSM, pointers, occupancy, packet count and overflow flag.
  // A terminator dropped on a full FIFO still closes the packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= WAIT;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if ((st == WAIT) && is_cmd(rsp)) st <= STORE;
      else if (term)                   st <= WAIT;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count   <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      pkt_cnt <= pkt_cnt + {{AW{1'b0}}, term} - {{AW{1'b0}}, pkt_done};
      if (wr_req && full) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/noc_switch_n.sv
// NOC fan-out switch: one upstream port to NDEV device ports. Requests are
// routed by destination ID through a 2-stage delay line; buffered device
// responses are merged upstream by a packet-granular round-robin arbiter.
module noc_switch_n
  import noc_pkg::*;
#(
  parameter int unsigned NDEV    = 4,
  parameter logic [7:0]  BASE_ID = 8'h40,
  parameter int unsigned DEPTH   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              to_ctl,
  input  logic [7:0]        to_data,
  output logic              from_ctl,
  output logic [7:0]        from_data,
  output logic [NDEV-1:0]   dev_to_ctl,
  output logic [8*NDEV-1:0] dev_to_data,
  input  logic [NDEV-1:0]   dev_from_ctl,
  input  logic [8*NDEV-1:0] dev_from_data,
  output logic              bad_dest,
  output logic [NDEV-1:0]   ovf
);

  localparam int unsigned PW    = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam logic [7:0]  NDEV8 = 8'(NDEV);

  noc_byte_t   req_in;
  noc_byte_t   d1;
  noc_byte_t   d2;
  req_st_t     req_st;
  logic [7:0]  dest_q;
  logic [7:0]  dest_off;
  logic [7:0]  id_off;
  logic        route_ok;

  noc_byte_t       head [NDEV];
  logic [NDEV-1:0] empty;
  logic [NDEV-1:0] has_pkt;
  logic [NDEV-1:0] pop;
  logic [NDEV-1:0] pkt_done;
  arb_st_t         arb_st;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant_q;
  logic [PW-1:0]   cur;
  logic            active;
  logic            term;
  int unsigned     idx;
  noc_byte_t       from_q;

  // Request delay line, destination capture and bad-destination flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1       <= NOC_NOP;
      d2       <= NOC_NOP;
      req_st   <= IDLE;
      dest_q   <= BASE_ID;
      bad_dest <= 1'b0;
    end else begin
      d1 <= req_in;
      d2 <= d1;
      case (req_st)
        IDLE, ROUTE: if (is_cmd(req_in)) req_st <= GOT_CMD;
        GOT_CMD: begin
          if (!req_in.ctl) begin
            req_st <= ROUTE;
            dest_q <= req_in.data;
            if (id_off >= NDEV8) bad_dest <= 1'b1;
          end
        end
        default: req_st <= IDLE;
      endcase
    end
  end

  // Steer the delayed byte to the addressed port; every other port sees NOP.
  always_comb begin
    req_in      = {to_ctl, to_data};
    id_off      = req_in.data - BASE_ID;
    dest_off    = dest_q - BASE_ID;
    route_ok    = (dest_off < NDEV8);
    dev_to_ctl  = {NDEV{NOP_CTL}};
    dev_to_data = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (route_ok && (dest_off == 8'(i))) begin
        dev_to_ctl[i]         = d2.ctl;
        dev_to_data[8*i +: 8] = d2.data;
      end
    end
  end

  for (genvar g = 0; g < NDEV; g++) begin : g_buf
    noc_byte_t rsp;

    // Pack the device response lane into a NOC byte.
    always_comb rsp = {dev_from_ctl[g], dev_from_data[8*g +: 8]};

    noc_rsp_buf #(.DEPTH(DEPTH)) u_buf (
      .clk      (clk),
      .reset    (reset),
      .rsp      (rsp),
      .pop      (pop[g]),
      .pkt_done (pkt_done[g]),
      .head     (head[g]),
      .empty    (empty[g]),
      .has_pkt  (has_pkt[g]),
      .ovf      (ovf[g])
    );
  end

  // Round-robin grant search from ptr while idle; locked grant while sending.
  // An empty FIFO mid-packet (terminator was dropped) also ends the packet.
  always_comb begin
    cur    = grant_q;
    active = 1'b0;
    idx    = 0;
    if (arb_st == A_SEND) begin
      active = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NDEV; k++) begin
        idx = (32'(ptr) + k) % NDEV;
        if (!active && has_pkt[idx]) begin
          active = 1'b1;
          cur    = PW'(idx);
        end
      end
    end
    term     = empty[cur] || is_nop(head[cur]);
    pop      = '0;
    pkt_done = '0;
    if (active) begin
      pop[cur]      = !empty[cur];
      pkt_done[cur] = term;
    end
  end

  // Arbiter state, rotation pointer and registered upstream output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_st  <= A_IDLE;
      ptr     <= '0;
      grant_q <= '0;
      from_q  <= NOC_NOP;
    end else begin
      from_q <= NOC_NOP;
      if (active) begin
        if (!empty[cur]) from_q <= head[cur];
        grant_q <= cur;
        if (term) begin
          arb_st <= A_IDLE;
          ptr    <= (cur == PW'(NDEV - 1)) ? '0 : cur + 1'b1;
        end else begin
          arb_st <= A_SEND;
        end
      end
    end
  end

  // Drive upstream response pins from the output register.
  always_comb begin
    from_ctl  = from_q.ctl;
    from_data = from_q.data;
  end

endmodule

// File: tb/tb_noc_switch_n.sv
// Bench for noc_switch_n: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based packet model of the switch.
module tb_noc_switch_n;

  localparam int         NDEV  = 4;
  localparam int         DEPTH = 16;
  localparam logic [7:0] BASE  = 8'h40;
  localparam logic [8:0] NOP9  = 9'h100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              to_ctl = 1'b1;
  logic [7:0]        to_data = 8'h00;
  logic              from_ctl;
  logic [7:0]        from_data;
  logic [NDEV-1:0]   dev_to_ctl;
  logic [8*NDEV-1:0] dev_to_data;
  logic [NDEV-1:0]   dev_from_ctl = '1;
  logic [8*NDEV-1:0] dev_from_data = '0;
  logic              bad_dest;
  logic [NDEV-1:0]   ovf;

  noc_switch_n #(.NDEV(NDEV), .BASE_ID(BASE), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .to_ctl        (to_ctl),
    .to_data       (to_data),
    .from_ctl      (from_ctl),
    .from_data     (from_data),
    .dev_to_ctl    (dev_to_ctl),
    .dev_to_data   (dev_to_data),
    .dev_from_ctl  (dev_from_ctl),
    .dev_from_data (dev_from_data),
    .bad_dest      (bad_dest),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: bytes are {ctl,data}; request port -1 = no port, -2 = bad id byte.
  logic [8:0]      reqq[$];
  int              reqp[$];
  logic [8:0]      rexp_b[4];
  int              rexp_p[4];
  logic [8:0]      txq[NDEV][$];
  logic [8:0]      dq[NDEV][$];
  int              tq[NDEV][$];
  int              ptr_m;
  int              cur_m;
  bit              send_m;
  logic            bad_m;
  logic [NDEV-1:0] ovf_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    reqq.delete();
    reqp.delete();
    for (int i = 0; i < 4; i++) begin
      rexp_b[i] = NOP9;
      rexp_p[i] = -1;
    end
    for (int d = 0; d < NDEV; d++) begin
      txq[d].delete();
      dq[d].delete();
      tq[d].delete();
    end
    ptr_m  = 0;
    cur_m  = 0;
    send_m = 0;
    bad_m  = 1'b0;
    ovf_m  = '0;
  endtask

  task automatic push_req(input logic [8:0] b, input int p);
    reqq.push_back(b);
    reqp.push_back(p);
  endtask

  // Queue one request packet: cmd, dest id, ndata bytes, then nops NOP bytes.
  task automatic add_req(input logic [7:0] id, input int ndata, input int nops);
    int off;
    bit ok;
    off = int'(id) - int'(BASE);
    ok  = (off >= 0) && (off < NDEV);
    push_req({1'b1, 8'($urandom_range(1, 255))}, ok ? off : -1);
    push_req({1'b0, id}, ok ? off : -2);
    repeat (ndata) push_req({1'b0, 8'($urandom)}, ok ? off : -1);
    repeat (nops) push_req(NOP9, -1);
  endtask

  // Queue one response packet on device d: cmd, ndata bytes, NOP terminator.
  task automatic add_rsp(input int d, input int ndata);
    txq[d].push_back({1'b1, 8'($urandom_range(1, 255))});
    repeat (ndata) txq[d].push_back({1'b0, 8'($urandom)});
    txq[d].push_back(NOP9);
  endtask

  // One clock: model the upstream response, drive inputs, check all outputs.
  task automatic step();
    logic [8:0]      exp_from;
    logic [8:0]      rb;
    int              p;
    logic            bad_next;
    logic [NDEV-1:0] ovf_next;
    logic [NDEV-1:0] ec;
    logic [8*NDEV-1:0] ed;
    @(posedge clk);
    #1;
    cyc++;
    // A packet is eligible two cycles after its terminator arrived.
    exp_from = NOP9;
    if (!send_m) begin
      for (int k = 0; k < NDEV; k++) begin
        int d;
        d = (ptr_m + k) % NDEV;
        if (!send_m && (tq[d].size() > 0) && (tq[d][0] <= cyc - 2)) begin
          send_m = 1;
          cur_m  = d;
        end
      end
    end
    if (send_m) begin
      if (dq[cur_m].size() > 0) exp_from = dq[cur_m].pop_front();
      if (exp_from == NOP9) begin
        send_m = 0;
        void'(tq[cur_m].pop_front());
        ptr_m = (cur_m + 1) % NDEV;
      end
    end
    // Upstream request byte and its expected appearance two cycles later.
    if (reqq.size() > 0) begin
      rb = reqq.pop_front();
      p  = reqp.pop_front();
    end else begin
      rb = NOP9;
      p  = -1;
    end
    {to_ctl, to_data} = rb;
    bad_next = (p == -2);
    rexp_b[(cyc + 2) % 4] = rb;
    rexp_p[(cyc + 2) % 4] = (p < 0) ? -1 : p;
    // Device responses into the per-device buffer model.
    ovf_next = '0;
    for (int d = 0; d < NDEV; d++) begin
      if (txq[d].size() > 0) begin
        rb = txq[d].pop_front();
        if (dq[d].size() < DEPTH) dq[d].push_back(rb);
        else ovf_next[d] = 1'b1;
        if (rb == NOP9) tq[d].push_back(cyc);
      end else begin
        rb = NOP9;
      end
      dev_from_ctl[d]          = rb[8];
      dev_from_data[8*d +: 8]  = rb[7:0];
    end
    @(negedge clk);
    ec = '1;
    ed = '0;
    p  = rexp_p[cyc % 4];
    rb = rexp_b[cyc % 4];
    if (p >= 0) begin
      ec[p]         = rb[8];
      ed[8*p +: 8]  = rb[7:0];
    end
    check("dev_to", 64'({dev_to_ctl, dev_to_data}), 64'({ec, ed}));
    check("from", 64'({from_ctl, from_data}), 64'(exp_from));
    check("bad_dest", 64'(bad_dest), 64'(bad_m));
    check("ovf", 64'(ovf), 64'(ovf_m));
    bad_m = bad_m | bad_next;
    ovf_m = ovf_m | ovf_next;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic rand_run(input int n);
    int nd;
    repeat (n) begin
      if (reqq.size() == 0) begin
        if ($urandom_range(0, 7) == 0) add_req(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 2));
        else add_req(BASE + 8'($urandom_range(0, NDEV - 1)), $urandom_range(0, 4), $urandom_range(0, 2));
      end
      for (int d = 0; d < NDEV; d++) begin
        if ((txq[d].size() == 0) && ($urandom_range(0, 5) == 0)) begin
          nd = $urandom_range(0, 4);
          if (dq[d].size() + nd + 2 <= DEPTH) add_rsp(d, nd);
        end
      end
      step();
    end
  endtask

  // Assert reset for n cycles with all outputs checked, then restart the model.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    to_ctl        = 1'b1;
    to_data       = 8'h00;
    dev_from_ctl  = '1;
    dev_from_data = '0;
    repeat (n) begin
      @(negedge clk);
      check("rst_dev_to", 64'({dev_to_ctl, dev_to_data}), 64'({{NDEV{1'b1}}, {8*NDEV{1'b0}}}));
      check("rst_from", 64'({from_ctl, from_data}), 64'(NOP9));
      check("rst_flags", 64'({bad_dest, ovf}), 64'(0));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset(3);

    // T2: cmd 81, id 42, data 10 20 reaches device 2 only.
    push_req(9'h181, 2);
    push_req(9'h042, 2);
    push_req(9'h010, 2);
    push_req(9'h020, 2);
    push_req(NOP9, -1);
    run(8);

    // T3: out-of-range id 47 dropped, then id 40 reaches device 0.
    add_req(8'h47, 2, 1);
    add_req(8'h40, 2, 1);
    run(10);
    check("T3_bad_dest", 64'(bad_dest), 64'(1));

    // T4: devices 0,1,3 respond together; then 3 and 0 together (ptr back at 0).
    add_rsp(0, 3);
    add_rsp(1, 3);
    add_rsp(3, 3);
    run(24);
    add_rsp(3, 1);
    add_rsp(0, 1);
    run(12);

    // T6: device 2 streams a second packet while the first is drained.
    add_rsp(2, 6);
    add_rsp(2, 10);
    run(40);
    check("T6_no_ovf", 64'(ovf), 64'(0));

    // Random traffic on both paths, including back-to-back and bad ids.
    rand_run(1500);

    // T1: reset in the middle of traffic, then a normal packet.
    rand_run(25);
    do_reset(3);
    add_req(8'h41, 3, 1);
    run(10);

    // T5: device 1 overruns its FIFO while device 0's packet is being sent.
    add_rsp(0, DEPTH - 2);
    run(DEPTH);
    add_rsp(1, DEPTH + 2);
    run(70);
    check("T5_ovf", 64'(ovf), 64'(4'b0010));
    add_rsp(1, 2);
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
